mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the 16-bit CPU's load/store and fetch traffic.
- Accepts one request at a time (address, write flag, store data) from the datapath/controller.
- Serves it from an internal word-addressed RAM or a small memory-mapped I/O window, after a programmable number of wait states.
- Returns read data with a one-cycle valid pulse. The controller holds the datapath stalled until that pulse.

Parameters:
- WIDTH, 16: data and address width.
- ADDRBITS, 10: RAM index bits; RAM depth is 2**ADDRBITS words.
- WAIT_STATES, 1: extra cycles between accept and access; range 0..15.
- IO_BASE, 16'hFF00: first address of the I/O window; the window runs from IO_BASE to 16'hFFFF.

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: responder can accept.
- req_write, input, 1: 1 = store, 0 = load.
- req_addr, input, WIDTH: word address.
- req_wdata, input, WIDTH: store data.
- resp_valid, output, 1: one-cycle completion pulse.
- resp_data, output, WIDTH: load data, or echoed store data.
- io_in, input, WIDTH: external input word (e.g. controller buttons); asynchronous to clk.
- io_out, output, WIDTH: registered output word.
- busy, output, 1: high whenever state is not IDLE.

Behaviour:
- Reset (reset low, async): state=IDLE, wait counter=0, resp_valid=0, resp_data=0, io_out=0, both io_in sync flops=0. Reset does not clear RAM contents. Reset mid-transaction abandons it: no resp_valid, no RAM write.
- Handshake: req_ready=1 only in IDLE. The request is accepted on a rising edge with req_valid && req_ready. At that edge req_addr, req_write and req_wdata are latched; later input changes are ignored until the next accept.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: on accept, go to WAIT if WAIT_STATES>0, else go to ACCESS.
  - WAIT: counter loads WAIT_STATES-1 on entry and decrements each cycle. Go to ACCESS when the counter is 0.
  - ACCESS: perform the RAM/IO read or write at the end of the cycle, then go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
- Latency and throughput:
  - Accept edge ends cycle N; resp_valid is high in cycle N+WAIT_STATES+2.
  - req_ready is high again in cycle N+WAIT_STATES+3.
  - Maximum throughput is one request per WAIT_STATES+3 cycles.
- Address decode (on latched address):
  - addr < IO_BASE: RAM; index = addr[ADDRBITS-1:0]. Upper bits are ignored, so addresses alias and wrap modulo depth.
  - addr == IO_BASE: read returns synchronized io_in; write ignored.
  - addr == IO_BASE+1: read returns io_out; write sets io_out to wdata at the ACCESS edge.
  - Other I/O addresses: read returns 0; write ignored.
- resp_data:
  - Load: the addressed word, as its value at the ACCESS edge.
  - Store: the latched wdata.
  - resp_data holds its value after resp_valid drops, until the next RESP.
- RAM: synchronous single-port, one read or write per access, no read-during-write hazard because there is a single access per transaction. RAM contents are undefined after power-up.
- io_in passes through a 2-flop synchronizer. An io_in change is visible to a load whose ACCESS cycle starts at least 2 cycles after the change.
- req_valid high in a non-IDLE state is not accepted and not lost. The requester must hold it until it sees req_ready.

Optional Feature:
- Macro: MEM_RESP_ERROR_EN.
- Defined:
  - Adds output resp_error, 1 bit, reset 0.
  - resp_error is high together with resp_valid when the latched address is in the I/O window but is neither IO_BASE nor IO_BASE+1, or is a write to IO_BASE.
  - Data behaviour is unchanged.
- Undefined: port absent; those accesses behave exactly as in Behaviour.

Test Plan:
- Reset/idle: hold reset low 3 cycles, release -> req_ready=1, busy=0, resp_valid=0, io_out=16'h0000, resp_data=16'h0000.
- Store/load: WAIT_STATES=1; store 16'hBEEF to address 16'h0010 accepted in cycle 0 -> resp_valid only in cycle 3 with resp_data=16'hBEEF. Then load 16'h0010 -> resp_data=16'hBEEF.
- Aliasing: ADDRBITS=10; store 16'h1234 to 16'h0405, then load 16'h0005 -> resp_data=16'h1234.
- I/O window:
  - Store 16'h00A5 to 16'hFF01 -> io_out=16'h00A5 from the cycle after ACCESS.
  - io_in=16'h0003, held 3 cycles, then load 16'hFF00 -> 16'h0003.
  - Load 16'hFF07 -> 16'h0000; with MEM_RESP_ERROR_EN, resp_error=1 on that response.
- Reset mid-operation: accept a store of 16'h5555 to 16'h0020 (previously 16'h1111), assert reset during WAIT -> no resp_valid, FSM returns to IDLE. A later load of 16'h0020 returns 16'h1111.
- Back-to-back: WAIT_STATES=0, req_valid held high with two loads -> accepts exactly 3 cycles apart, req_ready low in cycles 1-2, two single-cycle resp_valid pulses.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side responder for the 16-bit CPU. Takes one load/store
//            request at a time, waits WAIT_STATES cycles, then serves it
//            from an internal word-addressed RAM or a small memory-mapped
//            I/O window. Completion is a one-cycle resp_valid pulse.
// Ports    : clk, reset (async, active-low)
//            req_valid/req_ready/req_write/req_addr/req_wdata : request
//            resp_valid/resp_data                             : response
//            io_in (async, synchronized) / io_out (registered): I/O window
//            busy                                             : not IDLE
//            resp_error (only with MEM_RESP_ERROR_EN)         : bad I/O access
// Options  : `define MEM_RESP_ERROR_EN adds the resp_error output.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int               WIDTH       = 16,
  parameter int               ADDRBITS    = 10,
  parameter int               WAIT_STATES = 1,
  parameter logic [WIDTH-1:0] IO_BASE     = 16'hFF00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  output logic             busy
`ifdef MEM_RESP_ERROR_EN
  ,
  output logic             resp_error
`endif
);

  localparam int               c_DEPTH     = 1 << ADDRBITS;
  localparam logic [3:0]       c_WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [WIDTH-1:0] c_IO_OUT    = IO_BASE + WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_cnt;
  logic             r_write;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_resp_data;
  logic [WIDTH-1:0] r_io_out;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_ram [0:c_DEPTH-1];

  logic                w_accept;
  logic                w_is_ram;
  logic                w_is_in;
  logic                w_is_out;
  logic [ADDRBITS-1:0] w_ram_idx;
  logic [WIDTH-1:0]    w_rd_data;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  // Decode works on the latched address so the requester may change its
  // inputs freely once the request has been accepted.
  assign w_is_ram  = (r_addr < IO_BASE);
  assign w_is_in   = (r_addr == IO_BASE);
  assign w_is_out  = (r_addr == c_IO_OUT);
  assign w_ram_idx = r_addr[ADDRBITS-1:0];

  always_comb begin
    w_rd_data = '0;
    if (w_is_ram)      w_rd_data = r_ram[w_ram_idx];
    else if (w_is_in)  w_rd_data = r_sync2;
    else if (w_is_out) w_rd_data = r_io_out;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (r_cnt == 4'd0) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Request latch, wait counter, response data and output port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_resp_data <= '0;
      r_io_out    <= '0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= c_WAIT_INIT;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_ACCESS) begin
        // Stores echo their data; loads capture the word as of this edge.
        r_resp_data <= r_write ? r_wdata : w_rd_data;
        if (r_write && w_is_out) r_io_out <= r_wdata;
      end
    end
  end

  // Two-flop synchronizer for the asynchronous input word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= io_in;
      r_sync2 <= r_sync1;
    end
  end

  // RAM has no reset; contents survive a reset. A reset mid-transaction
  // forces IDLE, so the pending write never reaches ACCESS.
  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS && r_write && w_is_ram) r_ram[w_ram_idx] <= r_wdata;
  end

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_data  = r_resp_data;
  assign io_out     = r_io_out;

`ifdef MEM_RESP_ERROR_EN
  // Flag I/O-window accesses that hit nothing, and stores to the input port.
  assign resp_error = (r_state == S_RESP) && !w_is_ram &&
                      ((!w_is_in && !w_is_out) || (w_is_in && r_write));
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench for mem_responder. A vector table drives
//            loads/stores through a WAIT_STATES=1 instance; hand-written
//            sequences cover reset mid-transaction and back-to-back
//            requests on a WAIT_STATES=0 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic clk;
  logic reset;

  // Instance A: WAIT_STATES = 1
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [15:0] resp_data, io_in, io_out;
  logic        busy;
`ifdef MEM_RESP_ERROR_EN
  logic        resp_error;
  logic        b_resp_error;
`endif

  // Instance B: WAIT_STATES = 0
  logic        b_req_valid, b_req_ready, b_req_write;
  logic [15:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid;
  logic [15:0] b_resp_data, b_io_in, b_io_out;
  logic        b_busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(.WIDTH(16), .ADDRBITS(10), .WAIT_STATES(1), .IO_BASE(16'hFF00)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .io_in      (io_in),
    .io_out     (io_out),
    .busy       (busy)
`ifdef MEM_RESP_ERROR_EN
    ,
    .resp_error (resp_error)
`endif
  );

  mem_responder #(.WIDTH(16), .ADDRBITS(10), .WAIT_STATES(0), .IO_BASE(16'hFF00)) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (b_req_valid),
    .req_ready  (b_req_ready),
    .req_write  (b_req_write),
    .req_addr   (b_req_addr),
    .req_wdata  (b_req_wdata),
    .resp_valid (b_resp_valid),
    .resp_data  (b_resp_data),
    .io_in      (b_io_in),
    .io_out     (b_io_out),
    .busy       (b_busy)
`ifdef MEM_RESP_ERROR_EN
    ,
    .resp_error (b_resp_error)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_data;
    logic [15:0] exp_io;
    logic        exp_err;
  } vec_t;

  vec_t vecs [0:12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One request on instance A. Inputs are scrambled right after the accept
  // edge to prove the responder works from its latched copy.
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        output logic [15:0] data, output int lat, output logic err);
    @(negedge clk);
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~wr; req_addr = ~addr; req_wdata = ~wdata;
    lat = 0; data = 16'h0; err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat  = n;
        data = resp_data;
`ifdef MEM_RESP_ERROR_EN
        err  = resp_error;
`endif
        break;
      end
    end
  endtask

  logic [15:0] got_data;
  int          got_lat;
  logic        got_err;
  int          n_resp;
  int          n_acc;
  int          acc_at;
  logic        exp_rdy [0:7];
  logic        exp_rsp [0:7];

  initial begin
    vecs[0]  = '{1'b1, 16'h0010, 16'hBEEF, 16'hBEEF, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 16'h0405, 16'h1234, 16'h1234, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, 16'h0005, 16'h0000, 16'h1234, 16'h0000, 1'b0};
    vecs[4]  = '{1'b1, 16'hFF01, 16'h00A5, 16'h00A5, 16'h00A5, 1'b0};
    vecs[5]  = '{1'b0, 16'hFF01, 16'h0000, 16'h00A5, 16'h00A5, 1'b0};
    vecs[6]  = '{1'b0, 16'hFF00, 16'h0000, 16'h0003, 16'h00A5, 1'b0};
    vecs[7]  = '{1'b0, 16'hFF07, 16'h0000, 16'h0000, 16'h00A5, 1'b1};
    vecs[8]  = '{1'b1, 16'hFF00, 16'h7777, 16'h7777, 16'h00A5, 1'b1};
    vecs[9]  = '{1'b1, 16'hFEFF, 16'h0F0F, 16'h0F0F, 16'h00A5, 1'b0};
    vecs[10] = '{1'b0, 16'h02FF, 16'h0000, 16'h0F0F, 16'h00A5, 1'b0};
    vecs[11] = '{1'b1, 16'h0020, 16'h1111, 16'h1111, 16'h00A5, 1'b0};
    vecs[12] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h00A5, 1'b1};
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_rsp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0; req_wdata = 16'h0; io_in = 16'h0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 16'h0; b_req_wdata = 16'h0; b_io_in = 16'h0;

    // ---------------- reset / idle ----------------
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_req_ready",  {31'd0, req_ready},  32'd1);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_io_out",     {16'd0, io_out},     32'h0);
    check("rst_resp_data",  {16'd0, resp_data},  32'h0);

    // ---------------- vector table ----------------
    for (int i = 0; i < 13; i++) begin
      if (i == 6) begin
        io_in = 16'h0003;
        repeat (3) @(posedge clk);
      end
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, got_data, got_lat, got_err);
      check($sformatf("v%0d_latency", i), got_lat, 32'd3);
      check($sformatf("v%0d_data", i), {16'd0, got_data}, {16'd0, vecs[i].exp_data});
      check($sformatf("v%0d_io_out", i), {16'd0, io_out}, {16'd0, vecs[i].exp_io});
`ifdef MEM_RESP_ERROR_EN
      check($sformatf("v%0d_resp_error", i), {31'd0, got_err}, {31'd0, vecs[i].exp_err});
`endif
      @(negedge clk);
      check($sformatf("v%0d_pulse_end", i), {31'd0, resp_valid}, 32'd0);
      check($sformatf("v%0d_ready_again", i), {31'd0, req_ready}, 32'd1);
      check($sformatf("v%0d_data_hold", i), {16'd0, resp_data}, {16'd0, vecs[i].exp_data});
    end

    // ---------------- reset mid-transaction ----------------
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'h5555;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("midrst_busy_in_wait", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_idle",      {31'd0, req_ready}, 32'd1);
    check("midrst_io_out",    {16'd0, io_out},    32'h0);
    check("midrst_resp_data", {16'd0, resp_data}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    n_resp = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) n_resp++;
    end
    check("midrst_no_resp", n_resp, 32'd0);
    do_req(1'b0, 16'h0020, 16'h0000, got_data, got_lat, got_err);
    check("midrst_ram_kept", {16'd0, got_data}, 32'h1111);

    // ---------------- back-to-back, WAIT_STATES=0 ----------------
    n_acc = 0; acc_at = -1;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 16'h0001;
    for (int c = 0; c < 8; c++) begin
      check($sformatf("b2b_ready_c%0d", c), {31'd0, b_req_ready}, {31'd0, exp_rdy[c]});
      check($sformatf("b2b_resp_c%0d", c), {31'd0, b_resp_valid}, {31'd0, exp_rsp[c]});
      if (b_req_ready && b_req_valid) begin
        n_acc++;
        acc_at = c;
      end
      @(posedge clk);
      #1;
      if (n_acc == 1) b_req_addr = 16'h0002;
      if (n_acc == 2) b_req_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_accept_count", n_acc, 32'd2);
    check("b2b_second_accept_cycle", acc_at, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
